// File: rtl/disp_pkg.sv
// Shared constants and the hex-to-7-segment decode for the display scanner.
// Segment codes are active-low: bit7 = dp, bits6:0 = g..a.
package disp_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h92;
    localparam logic [7:0] SEG_6 = 8'h82;
    localparam logic [7:0] SEG_7 = 8'hF8;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h90;
    localparam logic [7:0] SEG_A = 8'h88;
    localparam logic [7:0] SEG_B = 8'h83;
    localparam logic [7:0] SEG_C = 8'hC6;
    localparam logic [7:0] SEG_D = 8'hA1;
    localparam logic [7:0] SEG_E = 8'h86;
    localparam logic [7:0] SEG_F = 8'h8E;

    // Decode one nibble; dp = 1 lights the decimal point (drives bit7 low).
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble, input logic dp);
        logic [7:0] s;
        s = SEG_BLANK;
        case (nibble)
            4'h0: s = SEG_0;
            4'h1: s = SEG_1;
            4'h2: s = SEG_2;
            4'h3: s = SEG_3;
            4'h4: s = SEG_4;
            4'h5: s = SEG_5;
            4'h6: s = SEG_6;
            4'h7: s = SEG_7;
            4'h8: s = SEG_8;
            4'h9: s = SEG_9;
            4'hA: s = SEG_A;
            4'hB: s = SEG_B;
            4'hC: s = SEG_C;
            4'hD: s = SEG_D;
            4'hE: s = SEG_E;
            4'hF: s = SEG_F;
            default: s = SEG_BLANK;
        endcase
        s[7] = ~dp;
        return s;
    endfunction

endpackage

// File: rtl/disp_scan_if.sv
// Display content/control bundle from the time-keeping datapath to the scanner.
// Plain level signals, no handshake: the scanner samples every field on every
// clock edge, so a change is visible on the next edge.
interface disp_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      en;
    logic [4*NUM_DIGITS-1:0]   hex_in;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic [NUM_DIGITS-1:0]     blank_in;
    logic [NUM_DIGITS-1:0]     blink_mask;
    logic                      lz_en;

    modport master (
        output en, hex_in, dp_in, blank_in, blink_mask, lz_en
    );

    modport slave (
        input en, hex_in, dp_in, blank_in, blink_mask, lz_en
    );
endinterface

// File: rtl/disp_seg_dec.sv
// Combinational segment decoder for the currently selected digit; dark forces
// every segment (including dp) off.
import disp_pkg::*;

module disp_seg_dec (
    input  logic [3:0] i_hex,
    input  logic       i_dp,
    input  logic       i_dark,
    output logic [7:0] o_seg
);

    // Dark overrides the decoded pattern.
    always_comb begin
        o_seg = SEG_BLANK;
        if (!i_dark) begin
            o_seg = hex_to_seg(i_hex, i_dp);
        end
    end

endmodule

// File: rtl/disp_scan.sv
// Time-multiplexed N-digit common-anode 7-segment driver. One digit owns each
// refresh slot; the first GUARD_CYCLES of a slot keep all anodes off so the
// previous digit's pattern does not ghost onto the next anode. Outputs are
// registered and reflect the slot/digit state of the previous cycle.
import disp_pkg::*;

module disp_scan #(
    parameter  int NUM_DIGITS   = 4,
    parameter  int REFRESH_DIV  = 50000,
    parameter  int GUARD_CYCLES = 2,
    parameter  int BLINK_DIV    = 25000000,
    localparam int IDX_W        = (NUM_DIGITS  > 1) ? $clog2(NUM_DIGITS)  : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    disp_scan_if.slave            bus,
    output logic [7:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic [IDX_W-1:0]      digit_idx
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BLK_W = (BLINK_DIV   > 1) ? $clog2(BLINK_DIV)   : 1;

    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_digit_idx;
    logic [BLK_W-1:0]      r_blink_cnt;
    logic                  r_blink_ph;
    logic [7:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_an;

    logic [3:0]            w_nib;
    logic                  w_dp;
    logic                  w_blank;
    logic                  w_blink;
    logic                  w_lz;
    logic [NUM_DIGITS-1:0] w_lz_mask;
    logic [NUM_DIGITS-1:0] w_an_sel;
    logic                  w_guard;
    logic                  w_dark;
    logic [7:0]            w_dec_seg;

    // Leading-zero mask: digit i is suppressed when it and every digit above it
    // are zero with no decimal point; digit 0 always stays lit.
    always_comb begin
        logic v_run;
        v_run     = 1'b1;
        w_lz_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            v_run        = v_run & (bus.hex_in[4*i +: 4] == 4'h0) & ~bus.dp_in[i];
            w_lz_mask[i] = bus.lz_en & v_run;
        end
    end

    // Select the fields of the digit owning the current slot, and its anode.
    always_comb begin
        w_nib    = 4'h0;
        w_dp     = 1'b0;
        w_blank  = 1'b0;
        w_blink  = 1'b0;
        w_lz     = 1'b0;
        w_an_sel = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_digit_idx == IDX_W'(i)) begin
                w_nib       = bus.hex_in[4*i +: 4];
                w_dp        = bus.dp_in[i];
                w_blank     = bus.blank_in[i];
                w_blink     = bus.blink_mask[i];
                w_lz        = w_lz_mask[i];
                w_an_sel[i] = 1'b0;
            end
        end
    end

    assign w_guard = int'(r_cnt) < GUARD_CYCLES;
    assign w_dark  = w_blank | (w_blink & r_blink_ph) | w_lz;

    disp_seg_dec u_dec (
        .i_hex  (w_nib),
        .i_dp   (w_dp),
        .i_dark (w_dark),
        .o_seg  (w_dec_seg)
    );

    // Slot counter with digit advance, and free-running blink counter; both freeze while disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_digit_idx <= '0;
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b0;
        end else if (bus.en) begin
            if (r_cnt == CNT_W'(REFRESH_DIV - 1)) begin
                r_cnt <= '0;
                if (r_digit_idx == IDX_W'(NUM_DIGITS - 1)) begin
                    r_digit_idx <= '0;
                end else begin
                    r_digit_idx <= r_digit_idx + 1'b1;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (r_blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
                r_blink_cnt <= '0;
                r_blink_ph  <= ~r_blink_ph;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    // Registered pin drive: disable and guard force everything dark.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg <= SEG_BLANK;
            r_an  <= '1;
        end else if (!bus.en || w_guard) begin
            r_seg <= SEG_BLANK;
            r_an  <= '1;
        end else begin
            r_seg <= w_dec_seg;
            r_an  <= w_an_sel;
        end
    end

    assign seg       = r_seg;
    assign an        = r_an;
    assign digit_idx = r_digit_idx;

endmodule

// File: tb/tb_disp_scan.sv
// Self-checking bench for disp_scan with a 4-cycle slot, 1-cycle guard and
// 16-cycle blink half-period.
`timescale 1ns/1ps
module tb_disp_scan;

  logic       clk;
  logic       rst;
  logic [7:0] seg;
  logic [3:0] an;
  logic [1:0] digit_idx;

  int n_cmp;
  int n_err;

  disp_scan_if #(.NUM_DIGITS(4)) u_if ();

  disp_scan #(
    .NUM_DIGITS   (4),
    .REFRESH_DIV  (4),
    .GUARD_CYCLES (1),
    .BLINK_DIV    (16)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (u_if),
    .seg       (seg),
    .an        (an),
    .digit_idx (digit_idx)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [15:0] hex;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        lz;
    logic [31:0] exp;   // {d3,d2,d1,d0} expected seg when lit slot
  } vec_t;

  vec_t vecs[9];

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic set_inputs(input logic [15:0] hex, input logic [3:0] dp, input logic [3:0] blank,
                            input logic [3:0] blink, input logic lz);
    u_if.hex_in     = hex;
    u_if.dp_in      = dp;
    u_if.blank_in   = blank;
    u_if.blink_mask = blink;
    u_if.lz_en      = lz;
  endtask

  // One full 16-cycle scan after reset, checking every cycle.
  task automatic run_scan(input vec_t v, input int vi);
    int         slot;
    int         pos;
    logic [3:0] e_an;
    logic [7:0] e_seg;
    logic [3:0] one;
    set_inputs(v.hex, v.dp, v.blank, 4'b0000, v.lz);
    u_if.en = 1'b1;
    apply_reset();
    check($sformatf("v%0d reset seg", vi), 32'(seg), 32'h0FF);
    check($sformatf("v%0d reset an", vi), 32'(an), 32'hF);
    check($sformatf("v%0d reset idx", vi), 32'(digit_idx), 32'h0);
    for (int k = 1; k <= 16; k++) begin
      step();
      slot = (k - 1) / 4;
      pos  = (k - 1) % 4;
      one  = 4'b0001;
      e_an  = (pos == 0) ? 4'hF : ~(one << slot);
      e_seg = (pos == 0) ? 8'hFF : v.exp[8*slot +: 8];
      check($sformatf("v%0d k%0d an", vi, k), 32'(an), 32'(e_an));
      check($sformatf("v%0d k%0d seg", vi, k), 32'(seg), 32'(e_seg));
      check($sformatf("v%0d k%0d idx", vi, k), 32'(digit_idx), 32'((k / 4) % 4));
    end
  endtask

  initial begin
    int         slot;
    int         pos;
    int         ph;
    logic [3:0] e_an;
    logic [7:0] e_seg;
    logic [3:0] one;
    logic [31:0] base;

    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    u_if.en = 1'b0;
    set_inputs(16'h0, 4'h0, 4'h0, 4'h0, 1'b0);

    vecs[0] = '{hex:16'h1234, dp:4'b0000, blank:4'b0000, lz:1'b0, exp:32'hF9A4B099};
    vecs[1] = '{hex:16'h0070, dp:4'b0000, blank:4'b0000, lz:1'b1, exp:32'hFFFFF8C0};
    vecs[2] = '{hex:16'h0070, dp:4'b0100, blank:4'b0000, lz:1'b1, exp:32'hFF40F8C0};
    vecs[3] = '{hex:16'h0000, dp:4'b0000, blank:4'b0000, lz:1'b1, exp:32'hFFFFFFC0};
    vecs[4] = '{hex:16'hABCD, dp:4'b0001, blank:4'b1010, lz:1'b0, exp:32'hFF83FF21};
    vecs[5] = '{hex:16'h5E6F, dp:4'b1000, blank:4'b0000, lz:1'b1, exp:32'h1286828E};
    vecs[6] = '{hex:16'h0000, dp:4'b0000, blank:4'b0000, lz:1'b0, exp:32'hC0C0C0C0};
    vecs[7] = '{hex:16'h0900, dp:4'b0000, blank:4'b0000, lz:1'b1, exp:32'hFF90C0C0};
    vecs[8] = '{hex:16'h8700, dp:4'b0000, blank:4'b0000, lz:1'b0, exp:32'h80F8C0C0};

    step();
    for (int vi = 0; vi < 9; vi++) begin
      run_scan(vecs[vi], vi);
    end

    // Blink: digits 1,0 dark during odd 16-cycle phases; 3,2 unaffected.
    set_inputs(16'h1234, 4'b0000, 4'b0000, 4'b0011, 1'b0);
    u_if.en = 1'b1;
    apply_reset();
    base = 32'hF9A4B099;
    for (int k = 1; k <= 48; k++) begin
      step();
      slot = ((k - 1) / 4) % 4;
      pos  = (k - 1) % 4;
      ph   = ((k - 1) / 16) % 2;
      one  = 4'b0001;
      e_an = (pos == 0) ? 4'hF : ~(one << slot);
      if (pos == 0 || (slot < 2 && ph == 1)) e_seg = 8'hFF;
      else e_seg = base[8*slot +: 8];
      check($sformatf("blink k%0d an", k), 32'(an), 32'(e_an));
      check($sformatf("blink k%0d seg", k), 32'(seg), 32'(e_seg));
    end

    // Enable drop mid-slot: dark next cycle, state frozen, resume in place.
    set_inputs(16'h1234, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    u_if.en = 1'b1;
    apply_reset();
    for (int k = 1; k <= 6; k++) step();
    check("pre-drop an", 32'(an), 32'hD);
    check("pre-drop seg", 32'(seg), 32'hB0);
    u_if.en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("dis%0d an", k), 32'(an), 32'hF);
      check($sformatf("dis%0d seg", k), 32'(seg), 32'hFF);
      check($sformatf("dis%0d idx", k), 32'(digit_idx), 32'h1);
    end
    u_if.en = 1'b1;
    step();
    check("resume1 an", 32'(an), 32'hD);
    check("resume1 seg", 32'(seg), 32'hB0);
    check("resume1 idx", 32'(digit_idx), 32'h1);
    step();
    check("resume2 an", 32'(an), 32'hD);
    check("resume2 idx", 32'(digit_idx), 32'h2);
    step();
    check("resume3 guard an", 32'(an), 32'hF);
    check("resume3 guard seg", 32'(seg), 32'hFF);
    step();
    check("resume4 an", 32'(an), 32'hB);
    check("resume4 seg", 32'(seg), 32'hA4);

    // Reset mid-slot on digit 2: back to digit 0 with a full guard.
    apply_reset();
    for (int k = 1; k <= 10; k++) step();
    check("pre-rst an", 32'(an), 32'hB);
    check("pre-rst idx", 32'(digit_idx), 32'h2);
    rst = 1'b1;
    step();
    check("mid-rst an", 32'(an), 32'hF);
    check("mid-rst seg", 32'(seg), 32'hFF);
    check("mid-rst idx", 32'(digit_idx), 32'h0);
    rst = 1'b0;
    step();
    check("post-rst guard an", 32'(an), 32'hF);
    check("post-rst guard seg", 32'(seg), 32'hFF);
    check("post-rst guard idx", 32'(digit_idx), 32'h0);
    step();
    check("post-rst d0 an", 32'(an), 32'hE);
    check("post-rst d0 seg", 32'(seg), 32'h99);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
